// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB-first, one full-adder cell and a carry flop.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, c_msb_q, c_msb_d, cout_q, cout_d, ovf_q, ovf_d, s, c;
  always_comb begin
    s = ra_q[0] ^ rb_q[0] ^ carry_q;
    c = (ra_q[0] & rb_q[0]) | (carry_q & (ra_q[0] ^ rb_q[0]));
    state_d = state_q;
    ra_d = ra_q;
    rb_d = rb_q;
    result_d = result_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q == SHIFT) begin
      result_d = {s, result_q[WIDTH-1:1]};
      ra_d = ra_q >> 1;
      rb_d = rb_q >> 1;
      carry_d = c;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 2)) c_msb_d = c;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cout_d = c;
        ovf_d = c ^ c_msb_q;
        state_d = DONE;
      end
    end else if (start) begin
      // subtraction as A + ~B + 1: invert B and seed the carry with sub
      ra_d = a;
      rb_d = b ^ {WIDTH{sub}};
      carry_d = sub;
      cnt_d = '0;
      state_d = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q <= '0;
      rb_q <= '0;
      result_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      result_q <= result_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign result = result_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for an 8-bit and an exhaustive 4-bit serial_addsub.
module tb_serial_addsub;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start8 = 1'b0, sub8 = 1'b0, start4 = 1'b0, sub4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, res8;
  logic [3:0] a4 = '0, b4 = '0, res4;
  logic busy8, done8, cout8, ovf8, busy4, done4, cout4, ovf4;
  int q8[$], q4[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8));
  serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4));
  function automatic int pk(int w, int c, int o, int r);
    return (c << (w + 1)) | (o << w) | r;
  endfunction
  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic int model(int w, int a, int b, int s);
    int m = 1 << w, h = 1 << (w - 1);
    int r = s ? a - b : a + b;
    int sa = a >= h ? a - m : a;
    int sb = b >= h ? b - m : b;
    int sr = s ? sa - sb : sa + sb;
    int c = s ? int'(a >= b) : int'(r >= m);
    return pk(w, c, int'(sr >= h || sr < -h), ((r % m) + m) % m);
  endfunction
  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  always @(negedge clk) if (done8) begin
    if (q8.size() == 0) chk("sb8_unexpected_done", 1, 0);
    else chk("sb8_result", int'({cout8, ovf8, res8}), q8.pop_front());
  end
  always @(negedge clk) if (done4) begin
    if (q4.size() == 0) chk("sb4_unexpected_done", 1, 0);
    else chk("sb4_result", int'({cout4, ovf4, res4}), q4.pop_front());
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait8(output int w, output int bc);
    w = 0;
    bc = 0;
    while (!done8 && w < 40) begin
      if (busy8) bc++;
      step();
      w++;
    end
    if (!done8) chk("timeout8", 0, 1);
  endtask
  task automatic op8(int a, int b, int s, int e);
    int w, bc;
    a8 = 8'(a);
    b8 = 8'(b);
    sub8 = s[0];
    start8 = 1'b1;
    q8.push_back(e);
    step();
    start8 = 1'b0;
    wait8(w, bc);
    step();
  endtask
  initial begin
    int w, bc, per_err;
    #3;
    chk("reset8", int'({busy8, done8, cout8, ovf8, res8}), 0);
    chk("reset4", int'({busy4, done4, cout4, ovf4, res4}), 0);
    step();
    rst_n = 1'b1;
    step();
    a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(pk(8, 0, 0, 'h7F));
    step();
    start8 = 1'b0;
    wait8(w, bc);
    chk("latency_edges", w, 8);
    chk("busy_cycles", bc, 8);
    step();
    chk("done_one_cycle", int'(done8), 0);
    op8('hFF, 'h01, 0, pk(8, 1, 0, 'h00));
    op8('h7F, 'h01, 0, pk(8, 0, 1, 'h80));
    op8('h10, 'h20, 1, pk(8, 0, 0, 'hF0));
    op8('h80, 'h01, 1, pk(8, 1, 1, 'h7F));
    op8('h5A, 'h00, 1, pk(8, 1, 0, 'h5A));
    // start pulses while busy must be ignored
    a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(pk(8, 0, 0, 'h7F));
    step();
    bc = 0;
    for (int c = 1; c <= 7; c++) begin
      if (busy8) bc++;
      start8 = (c == 3 || c == 5);
      if (start8) begin a8 = 8'h01; b8 = 8'h01; end
      step();
    end
    start8 = 1'b0;
    begin
      int w2, bc2;
      wait8(w2, bc2);
      chk("ignored_start_busy", bc + bc2, 8);
    end
    step();
    // asynchronous abort mid-operation
    a8 = 8'hC3; b8 = 8'h5E; sub8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (4) step();
    chk("busy_before_abort", int'(busy8), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_clears", int'({busy8, done8, cout8, ovf8, res8}), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_abort", int'({busy8, done8}), 0);
    op8('h35, 'h4A, 0, pk(8, 0, 0, 'h7F));
    // exhaustive WIDTH=4, start held high for back-to-back operation
    per_err = 0;
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i);
      b4 = 4'(i >> 4);
      sub4 = 1'(i >> 8);
      start4 = 1'b1;
      q4.push_back(model(4, i & 15, (i >> 4) & 15, i >> 8));
      step();
      w = 0;
      while (!done4 && w < 20) begin
        step();
        w++;
      end
      if (w != 4) per_err++;
    end
    start4 = 1'b0;
    step();
    chk("b2b_period4", per_err, 0);
    // randomized 8-bit with operand/start noise during SHIFT
    for (int n = 0; n < 150; n++) begin
      int ra = $urandom_range(0, 255), rb = $urandom_range(0, 255), rs = $urandom_range(0, 1);
      a8 = 8'(ra); b8 = 8'(rb); sub8 = rs[0]; start8 = 1'b1;
      q8.push_back(model(8, ra, rb, rs));
      step();
      w = 0;
      while (!done8 && w < 40) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        sub8 = 1'($urandom);
        start8 = 1'($urandom);
        step();
        w++;
      end
      start8 = 1'b0;
      if (!done8) chk("timeout8_rand", 0, 1);
      repeat ($urandom_range(0, 1)) step();
    end
    repeat (12) step();
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor built around one full-adder cell and a carry/borrow flip-flop.
- Processes two WIDTH-bit operands LSB-first, one bit per clock.
- Subtraction is A + ~B + 1, so the same serial datapath performs the inverse operation of the adder.
- Used where area matters more than latency; start/busy/done handshake to the surrounding control logic.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising edge; accepted only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result, cout and ovf valid.
- result  output  WIDTH  sum or difference (mod 2^WIDTH).
- cout  output  1  carry out; for subtract, 1 = no borrow (A >= B unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - busy, done, cout and ovf = 0; result = 0.
  - Internal shift registers, carry FF and counter = 0.
- States:
  - IDLE: waiting.
  - SHIFT: serial add in progress.
  - DONE: exactly one cycle.
- IDLE --start=1--> SHIFT, on the same edge:
  - ra <= a.
  - rb <= b XOR {WIDTH{sub}}.
  - carry <= sub.
  - cnt <= 0.
  - result is not cleared at this point; it is overwritten as the operation proceeds.
- SHIFT, every edge:
  - Compute s = ra[0]^rb[0]^carry; c = majority(ra[0], rb[0], carry).
  - result <= {s, result[WIDTH-1:1]}.
  - ra and rb shift right by 1.
  - carry <= c.
  - cnt <= cnt+1.
  - On the edge where cnt == WIDTH-2, capture the carry into the MSB (the c produced by bit WIDTH-2) into c_msb_in.
  - On the edge where cnt == WIDTH-1 (last bit): cout <= c; ovf <= c XOR c_msb_in; go to DONE.
- DONE: done = 1 for this cycle. Next state:
  - start=1 → SHIFT (back-to-back operation, same load as from IDLE).
  - otherwise → IDLE.
- Outputs:
  - busy = (state==SHIFT); done = (state==DONE). Both are decoded from registered state, so neither is combinational on inputs.
  - result, cout and ovf hold their values from DONE until the next operation's first SHIFT update.
  - During SHIFT, result is partial and is not to be consumed.
- Latency: start accepted at edge k → SHIFT over edges k+1 .. k+WIDTH → done high in the cycle after edge k+WIDTH. Total WIDTH+1 cycles from start to done.
- Throughput: one operation per WIDTH+1 cycles with start held or re-pulsed in DONE.
- Boundary conditions:
  - start while busy: ignored; operands not relatched; no effect on the current operation.
  - a, b and sub changing during SHIFT: no effect.
  - rst_n asserted mid-SHIFT: operation aborted immediately; all outputs return to reset values; no done pulse. After release, IDLE.
  - sub=1 with b=0: result = a, cout = 1.
  - WIDTH wrap-around: result is modulo 2^WIDTH; the overflowed bit appears only on cout.

Test Plan:
- Reset then a=0x35, b=0x4A, sub=0, start pulse → done exactly 9 cycles later; result=0x7F, cout=0, ovf=0; busy high for 8 cycles.
- a=0xFF, b=0x01, sub=0 → result=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, sub=0 → result=0x80, cout=0, ovf=1.
- a=0x10, b=0x20, sub=1 → result=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 → result=0x7F, cout=1, ovf=1.
- Exhaustive check at WIDTH=4:
  - All 16×16×2 combinations of a, b and sub.
  - Compare result, cout and ovf against a reference model.
  - Issue start held high during DONE to exercise back-to-back operations (5-cycle period).
- start pulses with different operands (a=0x01, b=0x01) during cycles 3 and 5 of an active 0x35+0x4A operation → ignored; done once with 0x7F; busy never drops early.
- rst_n driven low at cycle 4 of a SHIFT → busy, done, result, cout and ovf go to 0 immediately (before the next clock edge); no done pulse. A fresh start after release completes correctly.
